decoder_pipe: RTL and testbench
===============================

Name: decoder_pipe

Overview:
- Parametrised, pipelined N-to-2^N decoder with a valid/ready handshake. It is the successor to the fixed combinational 2-to-4 decoder.
- Used in MyCPU wherever a decoded select must be registered: regfile write-enable, byte-lane strobes, bank selects.
- Adds selectable decode modes, an enable gate, a configurable number of register stages, back-pressure, and a sticky error flag for the reserved mode.

Parameters:
IN_W, 2, select width; output width is OUT_W = 2**IN_W (legal range 1..6)
STAGES, 1, number of pipeline register stages (legal range 1..4); sets the latency

Ports:
clk  input  1  clock, rising edge
resetn  input  1  asynchronous, active-low reset
in_valid  input  1  input transfer request
in_ready  output  1  block can accept input this cycle
in_sel  input  IN_W  select index
in_mode  input  2  decode mode, captured with the transfer
in_en  input  1  0 forces a zero decode result
out_valid  output  1  out_data is valid
out_ready  input  1  downstream accepts
out_data  output  OUT_W  decoded vector
err  output  1  sticky: a reserved mode was accepted
err_clr  input  1  synchronous clear of err

Behaviour:
- Decode is combinational on the input side and is registered into stage 0. Each stage holds {valid, data[OUT_W]}.
- Decode modes, evaluated when in_en=1:
  - MODE_ONEHOT (00): bit in_sel set, all others 0.
  - MODE_THERM (01): bits 0..in_sel set, i.e. (2 << in_sel) - 1, truncated to OUT_W. For in_sel = OUT_W-1 all bits are set.
  - MODE_INV (10): bitwise NOT of one-hot.
  - MODE_RSVD (11): result is all-zero and err sets on the accepting edge.
- in_en=0: result is all-zero in every mode, including MODE_INV. err still sets if the mode is 11.
- Handshake:
  - A transfer occurs on an edge where valid=1 and ready=1.
  - Per stage i: ready_i = ~valid_i | ready_{i+1}, where ready_STAGES = out_ready.
  - in_ready = ready_0. The ready path is combinational back through all stages (no skid buffer).
  - A stage loads when ready_i=1: valid_i <= valid_{i-1} (in_valid for stage 0), data_i <= data_{i-1}.
  - Data is only loaded when the incoming valid is 1; otherwise data holds.
- Latency and throughput:
  - Latency is exactly STAGES cycles from an accepted input to out_valid, with out_ready held at 1.
  - Throughput is 1 transfer per cycle.
- Outputs: out_valid = valid_{STAGES-1}; out_data = data_{STAGES-1}.
- Stall: with out_ready=0 and the last stage valid, out_data and out_valid hold stable. Upstream stages keep filling until every stage is valid. in_ready then drops to 0 in the same cycle the pipe becomes full.
- Simultaneous events: in a full pipe, out_ready=1 and in_valid=1 in the same cycle produce a pop and a push on one edge. Occupancy is unchanged and in_ready stays 1.
- err:
  - Set on any accepted transfer with in_mode=11.
  - err_clr=1 clears it.
  - If set and clear occur on the same edge, set wins.
- Reset (asynchronous assert, synchronous deassert handled externally):
  - All valid bits = 0, all data = 0, err = 0.
  - Therefore out_valid = 0, out_data = 0, in_ready = 1.
  - Reset mid-operation discards all in-flight entries. No partial output appears after release.
- Width rule: all shifts are computed at OUT_W+1 bits, then truncated, so the MODE_THERM top index does not overflow.

Decomposition:
- Shared defines (defines.vh):
  - Mode constants MODE_ONEHOT, MODE_THERM, MODE_INV, MODE_RSVD.
  - Decode-mode field width (2).
- Sub-module decoder_pipe_stage:
  - One valid/data register with ready_i generation.
  - Parametrised by data width.
  - Instantiated STAGES times via a generate loop.
- The decode function stays in the top level.

Test Plan:
- Reset release, IN_W=2, STAGES=1: in_valid=1, sel=2, mode=00, en=1, out_ready=1 -> after 1 cycle out_valid=1, out_data=4'b0100; before that edge out_valid=0, out_data=0.
- Mode sweep, IN_W=3:
  - sel=5, mode=01 -> 8'b0011_1111.
  - sel=7, mode=01 -> 8'hFF.
  - sel=0, mode=10 -> 8'hFE.
  - en=0, mode=10 -> 8'h00.
- Back-pressure, STAGES=3: out_ready=0 while sel=0,1,2,3 are streamed -> in_ready falls after the 3rd accept. out_data holds 4'b0001 stable. Raising out_ready drains 0001, 0010, 0100, then accepts sel=3 -> 1000; order is preserved and nothing is lost.
- Full pipe, simultaneous pop and push, STAGES=2: one output per cycle with no bubble and in_ready constantly 1.
- Reserved mode: accept mode=11, sel=1 -> out_data=0 and err=1 from the next cycle. err_clr with no new mode 11 -> err=0. err_clr on the same edge as a mode-11 accept -> err stays 1.
- Reset asserted mid-stream, STAGES=4, 3 entries in flight -> out_valid=0 and out_data=0 immediately (asynchronous). After release, no stale entry appears at the output.

Source files
------------

// File: rtl/decoder_pipe_pkg.sv
// Shared decode-mode encoding for decoder_pipe.
package decoder_pipe_pkg;

    localparam int unsigned ModeW = 2;

    typedef enum logic [ModeW-1:0] {
        ModeOnehot = 2'b00,
        ModeTherm  = 2'b01,
        ModeInv    = 2'b10,
        ModeRsvd   = 2'b11
    } mode_e;

endpackage

// File: rtl/decoder_pipe_stage.sv
// One valid/data pipeline register; loads whenever it is empty or downstream accepts.
module decoder_pipe_stage #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [Width-1:0] data_i,
    input  logic             ready_dn_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o
);

    logic             ready;
    logic             valid_d, valid_q;
    logic [Width-1:0] data_d, data_q;

    always_comb begin
        ready   = ~valid_q | ready_dn_i;
        valid_d = valid_q;
        data_d  = data_q;
        if (ready) begin
            valid_d = valid_i;
            // Bubbles leave the data register untouched.
            if (valid_i) begin
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/decoder_pipe.sv
// Pipelined N-to-2^N decoder with valid/ready handshake and sticky reserved-mode error.
module decoder_pipe
    import decoder_pipe_pkg::*;
#(
    parameter int unsigned InW    = 2,
    parameter int unsigned Stages = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [InW-1:0]      in_sel_i,
    input  logic [ModeW-1:0]    in_mode_i,
    input  logic                in_en_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [2**InW-1:0]   out_data_o,
    output logic                err_o,
    input  logic                err_clr_i
);

    localparam int unsigned OutW = 2 ** InW;
    localparam int unsigned ExtW = OutW + 1;

    mode_e           mode;
    logic [OutW-1:0] onehot, therm, dec;

    // Shifts run one bit wider so the top thermometer index cannot overflow.
    always_comb begin
        mode   = mode_e'(in_mode_i);
        onehot = OutW'(ExtW'(1) << in_sel_i);
        therm  = OutW'((ExtW'(2) << in_sel_i) - ExtW'(1));
        dec    = '0;
        if (in_en_i) begin
            unique case (mode)
                ModeOnehot: dec = onehot;
                ModeTherm:  dec = therm;
                ModeInv:    dec = ~onehot;
                ModeRsvd:   dec = '0;
            endcase
        end
    end

    logic            valid_w [Stages+1];
    logic [OutW-1:0] data_w  [Stages+1];
    logic [Stages:0] ready_w;

    assign valid_w[0] = in_valid_i;
    assign data_w[0]  = dec;

    // Ready ripples back from the output through every stage, no skid buffer.
    always_comb begin
        ready_w         = '0;
        ready_w[Stages] = out_ready_i;
        for (int i = Stages - 1; i >= 0; i--) begin
            ready_w[i] = ~valid_w[i+1] | ready_w[i+1];
        end
    end

    for (genvar i = 0; i < Stages; i++) begin : g_stage
        decoder_pipe_stage #(
            .Width(OutW)
        ) u_stage (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .valid_i    (valid_w[i]),
            .data_i     (data_w[i]),
            .ready_dn_i (ready_w[i+1]),
            .valid_o    (valid_w[i+1]),
            .data_o     (data_w[i+1])
        );
    end

    logic err_d, err_q;

    // A reserved-mode accept on the same edge as a clear keeps the flag set.
    always_comb begin
        err_d = err_q;
        if (err_clr_i) begin
            err_d = 1'b0;
        end
        if (in_valid_i && ready_w[0] && (mode == ModeRsvd)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign in_ready_o  = ready_w[0];
    assign out_valid_o = valid_w[Stages];
    assign out_data_o  = data_w[Stages];
    assign err_o       = err_q;

endmodule

// File: tb/tb_decoder_pipe.sv
// Directed bench: four IN_W=2 pipes (1..4 stages) plus one IN_W=3 pipe on shared inputs.
module tb_decoder_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       in_en = 1'b1;
    logic       err_clr = 1'b0;
    logic [2:0] sel = '0;
    logic [1:0] mode = '0;

    logic       rdy [1:4];
    logic       ov  [1:4];
    logic       er  [1:4];
    logic [3:0] od  [1:4];

    logic       rdy_w, ov_w, er_w;
    logic [7:0] od_w;

    int unsigned n_vec  = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 1; g <= 4; g++) begin : g_dut
        decoder_pipe #(
            .InW(2),
            .Stages(g)
        ) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .in_valid_i  (in_valid),
            .in_ready_o  (rdy[g]),
            .in_sel_i    (sel[1:0]),
            .in_mode_i   (mode),
            .in_en_i     (in_en),
            .out_valid_o (ov[g]),
            .out_ready_i (out_ready),
            .out_data_o  (od[g]),
            .err_o       (er[g]),
            .err_clr_i   (err_clr)
        );
    end

    decoder_pipe #(
        .InW(3),
        .Stages(1)
    ) u_w3 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (rdy_w),
        .in_sel_i    (sel),
        .in_mode_i   (mode),
        .in_en_i     (in_en),
        .out_valid_o (ov_w),
        .out_ready_i (out_ready),
        .out_data_o  (od_w),
        .err_o       (er_w),
        .err_clr_i   (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_en     = 1'b1;
        err_clr   = 1'b0;
        sel       = '0;
        mode      = '0;
        rst_n     = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // {sel, mode, en, expected IN_W=3 decode}
    logic [13:0] sweep [8];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        sweep[0] = {3'd5, 2'b01, 1'b1, 8'h3F};
        sweep[1] = {3'd7, 2'b01, 1'b1, 8'hFF};
        sweep[2] = {3'd0, 2'b10, 1'b1, 8'hFE};
        sweep[3] = {3'd3, 2'b10, 1'b0, 8'h00};
        sweep[4] = {3'd0, 2'b01, 1'b1, 8'h01};
        sweep[5] = {3'd6, 2'b00, 1'b1, 8'h40};
        sweep[6] = {3'd2, 2'b10, 1'b1, 8'hFB};
        sweep[7] = {3'd5, 2'b00, 1'b0, 8'h00};

        // Reset state and latency of every pipe depth.
        reset_all();
        for (int g = 1; g <= 4; g++) begin
            check($sformatf("rst_rdy%0d", g), rdy[g], 1);
            check($sformatf("rst_ov%0d", g), ov[g], 0);
            check($sformatf("rst_od%0d", g), od[g], 0);
            check($sformatf("rst_err%0d", g), er[g], 0);
        end
        in_valid = 1'b1;
        sel      = 3'd2;
        mode     = 2'b00;
        check("pre_edge_ov1", ov[1], 0);
        for (int k = 1; k <= 5; k++) begin
            step();
            in_valid = 1'b0;
            for (int g = 1; g <= 4; g++) begin
                check($sformatf("lat_ov%0d_c%0d", g, k), ov[g], (k == g) ? 1 : 0);
                check($sformatf("lat_od%0d_c%0d", g, k), od[g], (k >= g) ? 4'b0100 : 4'b0000);
            end
        end

        // Mode sweep on the 3-bit select pipe, back to back.
        reset_all();
        for (int i = 0; i < 8; i++) begin
            logic [13:0] v;
            v        = sweep[i];
            in_valid = 1'b1;
            sel      = v[13:11];
            mode     = v[10:9];
            in_en    = v[8];
            step();
            check($sformatf("sweep_ov%0d", i), ov_w, 1);
            check($sformatf("sweep_od%0d", i), od_w, v[7:0]);
        end
        in_valid = 1'b0;
        in_en    = 1'b1;

        // Back-pressure on the 3-stage pipe.
        reset_all();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int s = 0; s < 3; s++) begin
            sel = 3'(s);
            check($sformatf("bp_rdy_pre%0d", s), rdy[3], 1);
            step();
        end
        sel = 3'd3;
        check("bp_full_rdy", rdy[3], 0);
        check("bp_full_ov", ov[3], 1);
        check("bp_full_od", od[3], 4'b0001);
        for (int k = 0; k < 2; k++) begin
            step();
            check($sformatf("bp_hold_od%0d", k), od[3], 4'b0001);
            check($sformatf("bp_hold_rdy%0d", k), rdy[3], 0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", rdy[3], 1);
        step();
        in_valid = 1'b0;
        check("bp_drain_od0", od[3], 4'b0010);
        for (int k = 1; k <= 2; k++) begin
            step();
            check($sformatf("bp_drain_ov%0d", k), ov[3], 1);
            check($sformatf("bp_drain_od%0d", k), od[3], 4'(1) << (k + 1));
        end
        step();
        check("bp_empty_ov", ov[3], 0);

        // Full 2-stage pipe with a pop and a push on every edge.
        reset_all();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 3'd0;
        step();
        sel = 3'd1;
        step();
        check("pp_full_rdy", rdy[2], 0);
        check("pp_full_od", od[2], 4'b0001);
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            sel = 3'((j + 2) % 4);
            #1;
            check($sformatf("pp_rdy%0d", j), rdy[2], 1);
            step();
            check($sformatf("pp_ov%0d", j), ov[2], 1);
            check($sformatf("pp_od%0d", j), od[2], 4'(1) << ((j + 1) % 4));
        end
        in_valid = 1'b0;

        // Sticky error flag.
        reset_all();
        in_valid = 1'b1;
        mode     = 2'b11;
        sel      = 3'd1;
        step();
        in_valid = 1'b0;
        mode     = 2'b00;
        check("err_set", er[1], 1);
        check("err_rsvd_od", od[1], 0);
        check("err_rsvd_ov", ov[1], 1);
        step();
        check("err_sticky", er[1], 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("err_clr", er[1], 0);
        in_valid = 1'b1;
        mode     = 2'b11;
        err_clr  = 1'b1;
        step();
        in_valid = 1'b0;
        mode     = 2'b00;
        err_clr  = 1'b0;
        check("err_set_wins", er[1], 1);

        // A reserved mode that is not accepted must not set the flag.
        reset_all();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        mode      = 2'b00;
        sel       = 3'd0;
        step();
        mode = 2'b11;
        check("err_stall_rdy1", rdy[1], 0);
        check("err_stall_rdy2", rdy[2], 1);
        step();
        in_valid = 1'b0;
        mode     = 2'b00;
        check("err_not_accepted", er[1], 0);
        check("err_accepted_s2", er[2], 1);

        // Enable low still flags the reserved mode.
        reset_all();
        in_en    = 1'b0;
        mode     = 2'b11;
        sel      = 3'd2;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_en    = 1'b1;
        mode     = 2'b00;
        check("en0_rsvd_err", er[1], 1);
        check("en0_rsvd_od", od[1], 0);

        // Asynchronous reset with entries in flight in the 4-stage pipe.
        reset_all();
        in_valid = 1'b1;
        for (int s = 1; s <= 3; s++) begin
            sel = 3'(s);
            step();
        end
        in_valid = 1'b0;
        step();
        check("ar_pre_ov", ov[4], 1);
        check("ar_pre_od", od[4], 4'b0010);
        rst_n = 1'b0;
        #1;
        check("ar_ov", ov[4], 0);
        check("ar_od", od[4], 0);
        check("ar_rdy", rdy[4], 1);
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("ar_post_ov%0d", k), ov[4], 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
